// File: rtl/pipe_adder.sv
// -----------------------------------------------------------------------------
// pipe_adder -- pipelined add/subtract unit with valid/ready handshakes.
//
// The WIDTH-bit operation is split into STAGES chunks of CW = WIDTH/STAGES
// bits. Stage k adds chunk k using the carry registered by stage k-1, so no
// combinational carry chain is longer than CW bits. The last stage's
// registers drive the outputs directly, giving a latency of STAGES cycles.
//
// Parameters
//   WIDTH     operand/result width in bits (>= 2)
//   STAGES    pipeline depth; WIDTH must be a multiple of STAGES
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   in_valid  operand set on a/b/sub/cin is valid
//   in_ready  pipeline can accept an operand set this cycle
//   a, b      operands
//   sub       0 = a + b + cin, 1 = a - b - cin
//   cin       carry-in (add) or borrow-in (subtract)
//   out_valid result on sum/cout/ovf is valid
//   out_ready downstream accepts the result this cycle
//   sum       result
//   cout      raw carry out of the MSB (1 = no borrow when subtracting)
//   ovf       two's-complement signed overflow
// -----------------------------------------------------------------------------
module pipe_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = WIDTH / STAGES;

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic             ovf_q;

  // Registered state of every stage, exposed so stage k can read stage k-1.
  logic             st_valid [STAGES];
  logic             st_carry [STAGES];
  logic [WIDTH-1:0] st_sum   [STAGES];
  logic [WIDTH-1:0] st_a     [STAGES];
  logic [WIDTH-1:0] st_b     [STAGES];

  // The whole pipeline moves as one: it advances whenever the output slot is
  // empty or being drained, otherwise every stage holds.
  assign adv      = !st_valid[STAGES-1] || out_ready;
  assign in_ready = adv;

  // Subtraction is a + ~b + ~cin, so a borrow-in becomes a missing carry-in.
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub ? ~cin : cin;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      logic             in_v;
      logic             in_c;
      logic [WIDTH-1:0] in_a;
      logic [WIDTH-1:0] in_b;
      logic [WIDTH-1:0] in_s;
      logic [CW:0]      add_w;

      logic             valid_d, valid_q;
      logic             carry_d, carry_q;
      logic [WIDTH-1:0] sum_d,   sum_q;
      logic [WIDTH-1:0] a_d,     a_q;
      logic [WIDTH-1:0] b_d,     b_q;

      if (gi == 0) begin : g_head
        assign in_v = in_valid;
        assign in_c = cin_eff;
        assign in_a = a;
        assign in_b = b_eff;
        assign in_s = '0;
      end else begin : g_link
        assign in_v = st_valid[gi-1];
        assign in_c = st_carry[gi-1];
        assign in_a = st_a[gi-1];
        assign in_b = st_b[gi-1];
        assign in_s = st_sum[gi-1];
      end

      // Operands are shifted right by CW after each stage, so the chunk to
      // add is always in the low CW bits of whatever arrives here.
      assign add_w = {1'b0, in_a[CW-1:0]} + {1'b0, in_b[CW-1:0]} + {{CW{1'b0}}, in_c};

      // The partial sum is shifted right as new chunks enter at the top;
      // after the final stage every chunk sits in its proper position.
      assign valid_d = in_v;
      assign carry_d = add_w[CW];
      assign sum_d   = (in_s >> CW) | (WIDTH'(add_w[CW-1:0]) << (WIDTH - CW));
      assign a_d     = in_a >> CW;
      assign b_d     = in_b >> CW;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_q <= 1'b0;
          carry_q <= 1'b0;
          sum_q   <= '0;
          a_q     <= '0;
          b_q     <= '0;
        end else if (adv) begin
          valid_q <= valid_d;
          carry_q <= carry_d;
          sum_q   <= sum_d;
          a_q     <= a_d;
          b_q     <= b_d;
        end
      end

      assign st_valid[gi] = valid_q;
      assign st_carry[gi] = carry_q;
      assign st_sum[gi]   = sum_q;
      assign st_a[gi]     = a_q;
      assign st_b[gi]     = b_q;

      // The final stage adds the top chunk, whose MSBs are the sign bits of
      // a and of the effective b, so overflow is resolved right here.
      if (gi == STAGES - 1) begin : g_tail
        logic ovf_d;

        assign ovf_d = (in_a[CW-1] == in_b[CW-1]) && (add_w[CW-1] != in_a[CW-1]);

        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            ovf_q <= 1'b0;
          end else if (adv) begin
            ovf_q <= ovf_d;
          end
        end
      end
    end
  endgenerate

  assign out_valid = st_valid[STAGES-1];
  assign sum       = st_sum[STAGES-1];
  assign cout      = st_carry[STAGES-1];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipe_adder.sv
// -----------------------------------------------------------------------------
// tb_pipe_adder -- directed, table-driven bench for pipe_adder.
// Instantiates the default 16-bit/4-stage configuration and a 4-bit/1-stage
// configuration; every expected value below was worked out by hand.
// -----------------------------------------------------------------------------
module tb_pipe_adder;

  logic        clk = 1'b0;
  logic        rst;

  // 16-bit, 4-stage instance
  logic        in_valid, in_ready, sub, cin, out_valid, out_ready, cout, ovf;
  logic [15:0] a, b, sum;

  // 4-bit, 1-stage instance
  logic        w4_in_valid, w4_in_ready, w4_sub, w4_cin;
  logic        w4_out_valid, w4_out_ready, w4_cout, w4_ovf;
  logic [3:0]  w4_a, w4_b, w4_sum;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_adder #(.WIDTH(16), .STAGES(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  pipe_adder #(.WIDTH(4), .STAGES(1)) dut_w4 (
    .clk(clk), .rst(rst),
    .in_valid(w4_in_valid), .in_ready(w4_in_ready),
    .a(w4_a), .b(w4_b), .sub(w4_sub), .cin(w4_cin),
    .out_valid(w4_out_valid), .out_ready(w4_out_ready),
    .sum(w4_sum), .cout(w4_cout), .ovf(w4_ovf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        cin;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int lat;
    int sent;
    int rcv;
    int stall_left;
    int stale;
    bit stalled;

    vecs[0]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[1]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2]  = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0};
    vecs[3]  = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    vecs[4]  = '{16'h1234, 16'h4321, 1'b0, 1'b1, 16'h5556, 1'b0, 1'b0};
    vecs[5]  = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[6]  = '{16'h0003, 16'h0001, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0};
    vecs[7]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[8]  = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[9]  = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[10] = '{16'h0000, 16'h0001, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};

    rst = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; cin = 1'b0; out_ready = 1'b1;
    w4_in_valid = 1'b0; w4_a = '0; w4_b = '0; w4_sub = 1'b0; w4_cin = 1'b0; w4_out_ready = 1'b1;

    // ---- reset state ----
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_w4_out_valid", 32'(w4_out_valid), 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;

    // ---- table: one operation at a time, latency and result ----
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = vecs[i].a; b = vecs[i].b; sub = vecs[i].sub; cin = vecs[i].cin;
      check("vec_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
        @(negedge clk);
        lat++;
      end
      $display("vec %0d: a=%h b=%h sub=%0d cin=%0d -> sum=%h cout=%0d ovf=%0d lat=%0d",
               i, vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin, sum, cout, ovf, lat);
      check("vec_latency", 32'(lat), 32'd4);
      check("vec_sum", 32'(sum), 32'(vecs[i].s));
      check("vec_cout", 32'(cout), 32'(vecs[i].co));
      check("vec_ovf", 32'(ovf), 32'(vecs[i].ov));
    end

    // ---- back-to-back stream with a 3-cycle stall after the 2nd result ----
    @(negedge clk);
    sent = 0; rcv = 0; stall_left = 0;
    for (int cyc = 0; cyc < 60 && rcv < 8; cyc++) begin
      if (cyc != 0) @(negedge clk);
      stalled   = (stall_left > 0);
      out_ready = !stalled;
      in_valid  = (sent < 8);
      a = 16'(sent); b = 16'(sent); sub = 1'b0; cin = 1'b0;
      #1;
      if (stalled) begin
        check("stall_in_ready", 32'(in_ready), 32'd0);
        check("stall_out_valid", 32'(out_valid), 32'd1);
        check("stall_sum_held", 32'(sum), 32'(2 * rcv));
        stall_left--;
      end
      if (out_valid && out_ready) begin
        $display("stream result %0d: sum=%h", rcv, sum);
        check("stream_sum", 32'(sum), 32'(2 * rcv));
        rcv++;
        if (rcv == 2) stall_left = 3;
      end
      if (in_valid && in_ready) sent++;
    end
    check("stream_count", 32'(rcv), 32'd8);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("stream_no_extra", 32'(out_valid), 32'd0);
    end

    // ---- asynchronous reset with operations in flight ----
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 16'h1000 + 16'(i); b = 16'h0001; sub = 1'b0; cin = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("flight_out_valid", 32'(out_valid), 32'd1);
    check("flight_sum", 32'(sum), 32'h1001);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    $display("async reset: out_valid=%0d sum=%h in_ready=%0d", out_valid, sum, in_ready);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_sum", 32'(sum), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    #2 rst = 1'b0;
    out_ready = 1'b1;
    stale = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("arst_no_stale", 32'(stale), 32'd0);
    in_valid = 1'b1; a = 16'h0102; b = 16'h0304; sub = 1'b0; cin = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    $display("post-reset op: sum=%h lat=%0d", sum, lat);
    check("arst_next_latency", 32'(lat), 32'd4);
    check("arst_next_sum", 32'(sum), 32'h0406);

    // ---- WIDTH=4, STAGES=1 ----
    @(negedge clk);
    w4_in_valid = 1'b1; w4_a = 4'hF; w4_b = 4'hF; w4_sub = 1'b0; w4_cin = 1'b1;
    @(negedge clk);
    w4_in_valid = 1'b0;
    $display("w4 F+F+1: sum=%h cout=%0d ovf=%0d", w4_sum, w4_cout, w4_ovf);
    check("w4_valid", 32'(w4_out_valid), 32'd1);
    check("w4_sum", 32'(w4_sum), 32'hF);
    check("w4_cout", 32'(w4_cout), 32'd1);
    check("w4_ovf", 32'(w4_ovf), 32'd0);
    w4_in_valid = 1'b1; w4_a = 4'h7; w4_b = 4'h1; w4_sub = 1'b0; w4_cin = 1'b0;
    @(negedge clk);
    w4_in_valid = 1'b0;
    $display("w4 7+1: sum=%h cout=%0d ovf=%0d", w4_sum, w4_cout, w4_ovf);
    check("w4_ovf_sum", 32'(w4_sum), 32'h8);
    check("w4_ovf_flag", 32'(w4_ovf), 32'd1);
    w4_in_valid = 1'b1; w4_a = 4'h3; w4_b = 4'h5; w4_sub = 1'b1; w4_cin = 1'b0;
    @(negedge clk);
    w4_in_valid = 1'b0;
    $display("w4 3-5: sum=%h cout=%0d ovf=%0d", w4_sum, w4_cout, w4_ovf);
    check("w4_sub_sum", 32'(w4_sum), 32'hE);
    check("w4_sub_cout", 32'(w4_cout), 32'd0);
    @(negedge clk);
    check("w4_drained", 32'(w4_out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
